latrsnq_stim_checker: RTL and testbench

//  Initiator/checker for a set/reset latch under test (LUT): generates E, D, RN, SETN

---
 rtl/latchk_pkg.sv | 66 ++++++
 rtl/latchk_lfsr.sv | 37 +++
 rtl/latrsnq_stim_checker.sv | 228 ++++++++++++++++++++++
 tb/tb_latrsnq_stim_checker.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latchk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : latchk_pkg                                                 |
// | Description : Shared types and helpers for the set/reset latch stimulus  |
// |               checker: FSM state enum, LFSR tap mask and default seed,   |
// |               vector-field bit positions and the vector decoder.         |
// | Macro       : LATCHK_RS_OVERLAP_EN - when defined, vectors may assert    |
// |               reset and set together; otherwise set is suppressed        |
// |               whenever reset is chosen.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package latchk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_APPLY = 3'd1,
      ST_OPEN  = 3'd2,
      ST_CLOSE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_CHECK = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // Vector fields inside the LFSR state.
   localparam int RA_LSB = 0;   // 2-bit field, reset when zero
   localparam int SA_LSB = 2;   // 2-bit field, set when zero
   localparam int D_BIT  = 4;   // data bit

   typedef struct packed {
      logic ra;
      logic sa;
      logic d;
   } vec_t;

   // A zero seed would lock the LFSR, so it is swapped for the default.
   function automatic logic [15:0] fix_seed(input logic [15:0] s);
      return (s == 16'h0000) ? DEFAULT_SEED : s;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], ^(l & LFSR_TAPS)};
   endfunction

   function automatic vec_t decode_vec(input logic [15:0] l);
      vec_t v;
      v.ra = (l[RA_LSB +: 2] == 2'b00);
      v.sa = (l[SA_LSB +: 2] == 2'b00);
      v.d  = l[D_BIT];
`ifdef LATCHK_RS_OVERLAP_EN
      // Reset and set may both be asserted; the latch resolves to reset.
      v.sa = v.sa;
`else
      // Never drive reset and set low together.
      if (v.ra && v.sa) begin
         v.sa = 1'b0;
      end
`endif
      return v;
   endfunction

endpackage : latchk_pkg
`default_nettype wire

// File: rtl/latchk_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : latchk_lfsr                                                |
// | Description : 16-bit Fibonacci LFSR used as the vector source. Load      |
// |               takes priority over step; a zero seed is replaced by the   |
// |               default seed so the all-zero state is unreachable.         |
// | Ports       : clk   - clock, rising edge                                 |
// |               rst_n - asynchronous active-low reset                      |
// |               load  - load seed (takes priority)                         |
// |               seed  - seed value                                         |
// |               step  - advance one step                                   |
// |               state - current LFSR state                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module latchk_lfsr
   import latchk_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DEFAULT_SEED;
      end else if (load) begin
         state <= fix_seed(seed);
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule : latchk_lfsr
`default_nettype wire

// File: rtl/latrsnq_stim_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : latrsnq_stim_checker                                       |
// | Description : Drives E/D/RN/SETN sequences into a set/reset latch under  |
// |               test, resynchronises its asynchronous Q and compares it    |
// |               against an internal reference, reporting pass, a           |
// |               saturating mismatch count and the first failing index.     |
// | Macro       : LATCHK_RS_OVERLAP_EN - allow vectors with RN and SETN low  |
// |               together (reset dominates).                                |
// | Ports       : CLK, RN          - clock / async active-low reset          |
// |               start            - run request (IDLE or DONE only)         |
// |               num_vec, seed    - run length and LFSR seed                |
// |               lut_e/d/rn/setn  - stimulus to the latch                   |
// |               lut_q            - latch output (asynchronous)             |
// |               busy, done, pass - run status                              |
// |               err_cnt          - saturating mismatch count               |
// |               first_err_idx    - first failing vector, all-ones if none  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module latrsnq_stim_checker
   import latchk_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 8,
   parameter int VEC_W       = 16
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             start,
   input  logic [VEC_W-1:0] num_vec,
   input  logic [15:0]      seed,
   output logic             lut_e,
   output logic             lut_d,
   output logic             lut_rn,
   output logic             lut_setn,
   input  logic             lut_q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [VEC_W-1:0] first_err_idx
);

   // A single flop is not a synchroniser, so the depth never drops below 2.
   localparam int                SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int                WAIT_W    = $clog2(SYNC_N);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SYNC_N - 1);

   state_t             state, state_nxt;
   logic [SYNC_N-1:0]  sync_q;
   logic               sync_out;
   logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic [VEC_W-1:0]   vec_idx, vec_idx_nxt;
   logic [VEC_W-1:0]   vec_total, vec_total_nxt;
   logic               exp_q, exp_q_nxt;
   logic               lut_e_nxt, lut_d_nxt, lut_rn_nxt, lut_setn_nxt;
   logic               busy_nxt, done_nxt, pass_nxt;
   logic [ERR_W-1:0]   err_cnt_nxt;
   logic [VEC_W-1:0]   first_err_idx_nxt;

   logic               lfsr_load, lfsr_step;
   logic [15:0]        lfsr_state;
   vec_t               cur_vec, next_vec, seed_vec;

   latchk_lfsr u_lfsr (
      .clk   (CLK),
      .rst_n (RN),
      .load  (lfsr_load),
      .seed  (seed),
      .step  (lfsr_step),
      .state (lfsr_state)
   );

   // Stimulus outputs are registered, so APPLY values are computed from the
   // LFSR value the register will hold once the transition has happened.
   assign cur_vec  = decode_vec(lfsr_state);
   assign next_vec = decode_vec(lfsr_next(lfsr_state));
   assign seed_vec = decode_vec(fix_seed(seed));

   // Resynchroniser for the asynchronous latch output.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_N-2:0], lut_q};
      end
   end
   assign sync_out = sync_q[SYNC_N-1];

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state         <= ST_IDLE;
         lut_e         <= 1'b0;
         lut_d         <= 1'b0;
         lut_rn        <= 1'b1;
         lut_setn      <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b1;
         err_cnt       <= '0;
         first_err_idx <= '1;
         exp_q         <= 1'b0;
         vec_idx       <= '0;
         vec_total     <= '0;
         wait_cnt      <= '0;
      end else begin
         state         <= state_nxt;
         lut_e         <= lut_e_nxt;
         lut_d         <= lut_d_nxt;
         lut_rn        <= lut_rn_nxt;
         lut_setn      <= lut_setn_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         pass          <= pass_nxt;
         err_cnt       <= err_cnt_nxt;
         first_err_idx <= first_err_idx_nxt;
         exp_q         <= exp_q_nxt;
         vec_idx       <= vec_idx_nxt;
         vec_total     <= vec_total_nxt;
         wait_cnt      <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      lut_e_nxt         = lut_e;
      lut_d_nxt         = lut_d;
      lut_rn_nxt        = lut_rn;
      lut_setn_nxt      = lut_setn;
      busy_nxt          = busy;
      done_nxt          = done;
      pass_nxt          = pass;
      err_cnt_nxt       = err_cnt;
      first_err_idx_nxt = first_err_idx;
      exp_q_nxt         = exp_q;
      vec_idx_nxt       = vec_idx;
      vec_total_nxt     = vec_total;
      wait_cnt_nxt      = wait_cnt;
      lfsr_load         = 1'b0;
      lfsr_step         = 1'b0;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               lfsr_load         = 1'b1;
               vec_total_nxt     = num_vec;
               vec_idx_nxt       = '0;
               err_cnt_nxt       = '0;
               first_err_idx_nxt = '1;
               pass_nxt          = 1'b1;
               done_nxt          = 1'b0;
               if (num_vec == '0) begin
                  // Empty run: finish immediately, stimulus left untouched.
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
               end else begin
                  state_nxt    = ST_APPLY;
                  busy_nxt     = 1'b1;
                  lut_e_nxt    = 1'b0;
                  lut_d_nxt    = seed_vec.d;
                  lut_rn_nxt   = ~seed_vec.ra;
                  lut_setn_nxt = ~seed_vec.sa;
               end
            end
         end

         ST_APPLY: begin
            state_nxt = ST_OPEN;
            lut_e_nxt = 1'b1;
         end

         ST_OPEN: begin
            // Close the latch and flip D so a leaky hold shows up as an error.
            state_nxt    = ST_CLOSE;
            lut_e_nxt    = 1'b0;
            lut_rn_nxt   = 1'b1;
            lut_setn_nxt = 1'b1;
            lut_d_nxt    = ~cur_vec.d;
            exp_q_nxt    = cur_vec.ra ? 1'b0 : (cur_vec.sa ? 1'b1 : cur_vec.d);
            wait_cnt_nxt = '0;
         end

         ST_CLOSE: begin
            state_nxt = ST_WAIT;
         end

         ST_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nxt = ST_CHECK;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end

         ST_CHECK: begin
            if (sync_out != exp_q) begin
               pass_nxt = 1'b0;
               if (err_cnt != {ERR_W{1'b1}}) begin
                  err_cnt_nxt = err_cnt + ERR_W'(1);
               end
               if (first_err_idx == {VEC_W{1'b1}}) begin
                  first_err_idx_nxt = vec_idx;
               end
            end
            lfsr_step   = 1'b1;
            vec_idx_nxt = vec_idx + VEC_W'(1);
            if (vec_idx == vec_total - VEC_W'(1)) begin
               state_nxt = ST_DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               state_nxt    = ST_APPLY;
               lut_e_nxt    = 1'b0;
               lut_d_nxt    = next_vec.d;
               lut_rn_nxt   = ~next_vec.ra;
               lut_setn_nxt = ~next_vec.sa;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule : latrsnq_stim_checker
`default_nettype wire

// File: tb/tb_latrsnq_stim_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_latrsnq_stim_checker                                    |
// | Description : Self-checking bench for latrsnq_stim_checker. A behavioural|
// |               latch (ideal, stuck-low, D-ignoring, inverted) drives      |
// |               lut_q; a per-vector reference model predicts the results.  |
// | Macro       : LATCHK_RS_OVERLAP_EN - selects the overlap expectations.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_latrsnq_stim_checker;

   logic        CLK = 1'b0;
   logic        RN = 1'b0;
   logic        start = 1'b0;
   logic [15:0] num_vec = '0;
   logic [15:0] seed = '0;
   logic        lut_e, lut_d, lut_rn, lut_setn, lut_q;
   logic        busy, done, pass;
   logic [7:0]  err_cnt;
   logic [15:0] first_err_idx;

   int errors = 0;
   int checks = 0;

   // Latch behaviour: 0 ideal, 1 stuck low, 2 ignores D while open, 3 inverted.
   int   mode = 0;
   logic lq = 1'b0;
   logic clr_lq = 1'b0;
   int   ovl_cycles = 0;

   latrsnq_stim_checker dut (
      .CLK           (CLK),
      .RN            (RN),
      .start         (start),
      .num_vec       (num_vec),
      .seed          (seed),
      .lut_e         (lut_e),
      .lut_d         (lut_d),
      .lut_rn        (lut_rn),
      .lut_setn      (lut_setn),
      .lut_q         (lut_q),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_cnt       (err_cnt),
      .first_err_idx (first_err_idx)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (clr_lq)                      lq <= 1'b0;
      else if (!lut_rn)                lq <= 1'b0;
      else if (!lut_setn)              lq <= 1'b1;
      else if (lut_e && mode != 2)     lq <= lut_d;
   end

   always @(negedge CLK) begin
      if (!lut_rn && !lut_setn) ovl_cycles <= ovl_cycles + 1;
   end

   assign lut_q = (mode == 1) ? 1'b0 : ((mode == 3) ? ~lq : lq);

   // Reference: walks the vector sequence and predicts errors, first index
   // and the number of cycles with RN and SETN both low.
   task automatic model(input int n, input logic [15:0] sd, input int md,
                        output int e_err, output int e_first, output int e_ovl);
      logic [15:0] l;
      logic ra, sa, d, ex, q, obs, fb;
      l = (sd == 16'h0000) ? 16'hACE1 : sd;
      q = 1'b0;
      e_err = 0;
      e_first = 16'hFFFF;
      e_ovl = 0;
      for (int i = 0; i < n; i++) begin
         ra = (l[1:0] == 2'b00);
         sa = (l[3:2] == 2'b00);
         d  = l[4];
`ifdef LATCHK_RS_OVERLAP_EN
         if (ra && sa) e_ovl += 2;
`else
         if (ra) sa = 1'b0;
`endif
         ex = ra ? 1'b0 : (sa ? 1'b1 : d);
         if (ra)            q = 1'b0;
         else if (sa)       q = 1'b1;
         else if (md != 2)  q = d;
         obs = (md == 1) ? 1'b0 : ((md == 3) ? ~q : q);
         if (obs != ex) begin
            if (e_err < 255) e_err++;
            if (e_first == 16'hFFFF) e_first = i;
         end
         fb = l[15] ^ l[13] ^ l[12] ^ l[10];
         l  = {l[14:0], fb};
      end
   endtask

   // Drives one run; cyc = rising edges from the start edge until done
   // (inclusive), or -1 on timeout. poke>0 pulses a stray start at that edge.
   task automatic do_run(input int n, input logic [15:0] sd, input int md,
                         input int poke, output int cyc, output int ovl);
      int base;
      mode = md;
      clr_lq = 1'b1;
      @(negedge CLK);
      clr_lq = 1'b0;
      @(posedge CLK); #1;
      base = ovl_cycles;
      start = 1'b1; num_vec = 16'(n); seed = sd;
      @(posedge CLK); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < n * 6 + 50) begin
         if (cyc == poke) begin
            start = 1'b1; num_vec = 16'd500; seed = 16'h1234;
         end
         @(posedge CLK); #1;
         start = 1'b0;
         cyc++;
      end
      if (!done) cyc = -1;
      @(negedge CLK);
      ovl = ovl_cycles - base;
   endtask

   task automatic test_reset();
      // Reset held while start is pulsed: reset must win.
      start = 1'b1; num_vec = 16'd5; seed = 16'h0001;
      @(posedge CLK); #1;
      start = 1'b0;
      checks++; if ({lut_e, lut_d, lut_rn, lut_setn} !== 4'b0011) begin errors++;
         $display("FAIL reset_lut: got %b expected 0011", {lut_e, lut_d, lut_rn, lut_setn}); end
      checks++; if ({busy, done, pass} !== 3'b001) begin errors++;
         $display("FAIL reset_status: got %b expected 001", {busy, done, pass}); end
      checks++; if (err_cnt !== 8'd0) begin errors++;
         $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
      checks++; if (first_err_idx !== 16'hFFFF) begin errors++;
         $display("FAIL reset_first_idx: got %h expected ffff", first_err_idx); end
      @(negedge CLK); RN = 1'b1;
      @(posedge CLK); #1;
      checks++; if ({busy, done} !== 2'b00) begin errors++;
         $display("FAIL reset_idle: got %b expected 00", {busy, done}); end
   endtask

   task automatic test_zero_vec();
      int cyc, ovl;
      do_run(0, 16'h0001, 0, 0, cyc, ovl);
      checks++; if (cyc !== 1) begin errors++;
         $display("FAIL zero_latency: got %0d expected 1", cyc); end
      checks++; if ({busy, done, pass} !== 3'b011) begin errors++;
         $display("FAIL zero_status: got %b expected 011", {busy, done, pass}); end
      checks++; if ({lut_e, lut_d, lut_rn, lut_setn} !== 4'b0011) begin errors++;
         $display("FAIL zero_lut: got %b expected 0011", {lut_e, lut_d, lut_rn, lut_setn}); end
      checks++; if (first_err_idx !== 16'hFFFF) begin errors++;
         $display("FAIL zero_first_idx: got %h expected ffff", first_err_idx); end
   endtask

   task automatic test_ideal();
      int cyc, ovl, e_err, e_first, e_ovl;
      model(100, 16'h0001, 0, e_err, e_first, e_ovl);
      do_run(100, 16'h0001, 0, 0, cyc, ovl);
      checks++; if (cyc !== 601) begin errors++;
         $display("FAIL ideal_cycles: got %0d expected 601", cyc); end
      checks++; if (err_cnt !== 8'(e_err) || e_err != 0) begin errors++;
         $display("FAIL ideal_err_cnt: got %0d expected %0d", err_cnt, e_err); end
      checks++; if ({busy, done, pass} !== 3'b011) begin errors++;
         $display("FAIL ideal_status: got %b expected 011", {busy, done, pass}); end
      checks++; if (first_err_idx !== 16'hFFFF) begin errors++;
         $display("FAIL ideal_first_idx: got %h expected ffff", first_err_idx); end
   endtask

   task automatic test_faulty(input int md, input int n, input string nm);
      int cyc, ovl, e_err, e_first, e_ovl;
      logic [15:0] sd;
      sd = 16'($urandom);
      model(n, sd, md, e_err, e_first, e_ovl);
      do_run(n, sd, md, 0, cyc, ovl);
      checks++; if (cyc !== n * 6 + 1) begin errors++;
         $display("FAIL %s_cycles: got %0d expected %0d", nm, cyc, n * 6 + 1); end
      checks++; if (err_cnt !== 8'(e_err)) begin errors++;
         $display("FAIL %s_err_cnt: seed %h got %0d expected %0d", nm, sd, err_cnt, e_err); end
      checks++; if (first_err_idx !== 16'(e_first)) begin errors++;
         $display("FAIL %s_first_idx: seed %h got %0d expected %0d", nm, sd, first_err_idx, e_first); end
      checks++; if (pass !== (e_err == 0)) begin errors++;
         $display("FAIL %s_pass: got %b expected %b", nm, pass, (e_err == 0)); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         test_faulty($urandom_range(0, 3), $urandom_range(1, 30), "random");
      end
   endtask

   task automatic test_saturate();
      int cyc, ovl, e_err, e_first, e_ovl;
      model(300, 16'h00A5, 3, e_err, e_first, e_ovl);
      do_run(300, 16'h00A5, 3, 0, cyc, ovl);
      checks++; if (err_cnt !== 8'(e_err) || e_err != 255) begin errors++;
         $display("FAIL sat_err_cnt: got %0d expected %0d", err_cnt, e_err); end
      checks++; if (first_err_idx !== 16'(e_first)) begin errors++;
         $display("FAIL sat_first_idx: got %0d expected %0d", first_err_idx, e_first); end
      checks++; if (pass !== 1'b0) begin errors++;
         $display("FAIL sat_pass: got %b expected 0", pass); end
   endtask

   task automatic test_reset_midrun();
      int cyc, ovl, e_err, e_first, e_ovl;
      logic [15:0] sd;
      mode = 0;
      @(posedge CLK); #1;
      start = 1'b1; num_vec = 16'd20; seed = 16'h0BEE;
      @(posedge CLK); #1;
      start = 1'b0;
      cyc = 1;
      // Edge 45 after the start edge enters WAIT of vector 7.
      while (cyc < 46) begin @(posedge CLK); #1; cyc++; end
      RN = 1'b0;
      #1;
      checks++; if ({lut_e, lut_d, lut_rn, lut_setn} !== 4'b0011) begin errors++;
         $display("FAIL abort_lut: got %b expected 0011", {lut_e, lut_d, lut_rn, lut_setn}); end
      checks++; if ({busy, done, pass} !== 3'b001) begin errors++;
         $display("FAIL abort_status: got %b expected 001", {busy, done, pass}); end
      checks++; if (err_cnt !== 8'd0 || first_err_idx !== 16'hFFFF) begin errors++;
         $display("FAIL abort_counters: got %0d/%h expected 0/ffff", err_cnt, first_err_idx); end
      @(negedge CLK); RN = 1'b1;
      sd = 16'($urandom);
      model(10, sd, 0, e_err, e_first, e_ovl);
      do_run(10, sd, 0, 0, cyc, ovl);
      checks++; if (cyc !== 61) begin errors++;
         $display("FAIL rerun_cycles: got %0d expected 61", cyc); end
      checks++; if (err_cnt !== 8'(e_err) || pass !== 1'b1) begin errors++;
         $display("FAIL rerun_result: got %0d/%b expected %0d/1", err_cnt, pass, e_err); end
   endtask

   task automatic test_back_to_back();
      int cyc, ovl, e_err, e_first, e_ovl;
      model(5, 16'h4321, 2, e_err, e_first, e_ovl);
      do_run(5, 16'h4321, 2, 10, cyc, ovl);
      checks++; if (cyc !== 31) begin errors++;
         $display("FAIL ignore_start_cycles: got %0d expected 31", cyc); end
      checks++; if (err_cnt !== 8'(e_err)) begin errors++;
         $display("FAIL ignore_start_err: got %0d expected %0d", err_cnt, e_err); end
      repeat (5) @(posedge CLK);
      #1;
      checks++; if (done !== 1'b1) begin errors++;
         $display("FAIL done_hold: got %b expected 1", done); end
      start = 1'b1; num_vec = 16'd3; seed = 16'h0777;
      @(posedge CLK); #1;
      start = 1'b0;
      checks++; if ({busy, done} !== 2'b10) begin errors++;
         $display("FAIL restart_status: got %b expected 10", {busy, done}); end
      cyc = 1;
      while (!done && cyc < 100) begin @(posedge CLK); #1; cyc++; end
      checks++; if (cyc !== 19) begin errors++;
         $display("FAIL restart_cycles: got %0d expected 19", cyc); end
   endtask

   task automatic test_overlap();
      int cyc, ovl, e_err, e_first, e_ovl;
      model(64, 16'h0003, 0, e_err, e_first, e_ovl);
      do_run(64, 16'h0003, 0, 0, cyc, ovl);
      checks++; if (ovl !== e_ovl) begin errors++;
         $display("FAIL overlap_cycles: got %0d expected %0d", ovl, e_ovl); end
      checks++; if (err_cnt !== 8'd0 || pass !== 1'b1) begin errors++;
         $display("FAIL overlap_result: got %0d/%b expected 0/1", err_cnt, pass); end
      checks++; if (cyc !== 385) begin errors++;
         $display("FAIL overlap_cycles_run: got %0d expected 385", cyc); end
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      test_reset();
      test_zero_vec();
      test_ideal();
      test_faulty(1, 50, "tied_low");
      test_faulty(2, 60, "defective");
      test_random();
      test_saturate();
      test_reset_midrun();
      test_back_to_back();
      test_overlap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_latrsnq_stim_checker
`default_nettype wire
